// File: rtl/sound_event_scheduler_pkg.sv
// Shared types and helpers for the sound event scheduler: FSM states,
// player ids, FIFO push record and the hit-to-tone reduction.
package sound_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, PLAY, GAP} state_t;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;
  localparam logic [7:0] DROP_MAX = 8'd255;

  typedef struct packed {
    logic       vld;
    logic [7:0] code;
  } push_t;

  // Highest set lane wins; P1 drives the low nibble, P2 the high nibble.
  function automatic logic [7:0] hit_to_code(input logic player, input logic [3:0] nibble);
    logic [3:0] top;
    top = '0;
    for (int i = 0; i < 4; i++) begin
      if (nibble[i]) begin
        top    = '0;
        top[i] = 1'b1;
      end
    end
    return player ? {top, 4'b0000} : {4'b0000, top};
  endfunction
endpackage

// File: rtl/sound_event_fifo.sv
// Tone-code FIFO with two ordered push ports (a lands before b) and one pop.
module sound_event_fifo
  import sound_sched_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  push_t                     push_a,
  input  push_t                     push_b,
  input  logic                      pop,
  output logic [7:0]                head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, wr_b;

  assign wr_b  = push_a.vld ? wr_ptr + AW'(1) : wr_ptr;
  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push_a.vld) mem[wr_ptr] <= push_a.code;
    if (push_b.vld) mem[wr_b]   <= push_b.code;
  end

  // Pointers wrap naturally since QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_a.vld) + AW'(push_b.vld);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_a.vld) + CW'(push_b.vld) - CW'(pop);
    end
  end
endmodule

// File: rtl/sound_event_scheduler.sv
// Turns player hit edges into queued one-hot tone pulses for the buzzer
// driver, arbitrating ties round-robin and spacing tones by tone+gap time.
module sound_event_scheduler
  import sound_sched_pkg::*;
#(
  parameter int TONE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int QDEPTH      = 4,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] p1_hit,
  input  logic [3:0] p2_hit,
  output logic [7:0] sound,
  output logic       busy,
  output logic       q_full,
  output logic [7:0] drop_cnt
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] TONE_LD = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  logic [1:0][3:0] hit, prev_hit;
  logic [1:0]      req;
  logic [1:0][7:0] code;
  logic            rr_last, winner, pop, empty, full;
  logic [CW-1:0]   count, free;
  logic [7:0]      head;
  logic [1:0]      n_drop;
  logic [8:0]      drop_sum;
  push_t           push_a, push_b;
  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign hit = {p2_hit, p1_hit};

  for (genvar p = 0; p < 2; p++) begin : g_player
    localparam logic PID = 1'(p);
    assign req[p]  = enable && (hit[p] != 4'b0) && (prev_hit[p] == 4'b0);
    assign code[p] = hit_to_code(PID, hit[p]);
  end

  always_ff @(posedge clk) begin
    if (rst) prev_hit <= '0;
    else     prev_hit <= hit;
  end

  // A same-cycle pop frees its slot before pushes are judged.
  assign free   = CW'(QDEPTH) - count + CW'(pop);
  assign winner = ~rr_last;

  always_comb begin
    push_a = '0;
    push_b = '0;
    n_drop = 2'd0;
    if (req[0] && req[1]) begin
      push_a = '{vld: free >= CW'(1), code: code[winner]};
      push_b = '{vld: free >= CW'(2), code: code[~winner]};
      n_drop = 2'(!push_a.vld) + 2'(!push_b.vld);
    end else if (req[0] || req[1]) begin
      push_a = '{vld: free != '0, code: req[0] ? code[0] : code[1]};
      n_drop = 2'(!push_a.vld);
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 9'(n_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last  <= P2;
      drop_cnt <= '0;
    end else begin
      if (req[0] && req[1]) rr_last <= winner;
      if (n_drop != 2'd0)
        drop_cnt <= (drop_sum > 9'(DROP_MAX)) ? DROP_MAX : drop_sum[7:0];
    end
  end

  sound_event_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (!enable),
    .push_a(push_a),
    .push_b(push_b),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE:  if (!empty) state_nxt = ISSUE;
      ISSUE: begin
        pop       = 1'b1;
        cnt_nxt   = TONE_LD;
        state_nxt = PLAY;
      end
      PLAY: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else if (GAP_CYCLES == 0) state_nxt = IDLE;
        else begin
          cnt_nxt   = GAP_LD;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pop       = 1'b0;
    end
  end

  // sound is loaded on entry to ISSUE so the pulse lines up with that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sound <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sound <= (state_nxt == ISSUE) ? head : 8'h00;
    end
  end

  assign busy   = (state != IDLE) || !empty;
  assign q_full = full;
endmodule

// File: tb/tb_sound_event_scheduler.sv
// Bench for sound_event_scheduler: vector table, directed corner sequences and
// random traffic checked every cycle against a queue/timestamp reference model.
module tb_sound_event_scheduler;
  localparam int TONE = 4;
  localparam int GAP  = 2;
  localparam int QD   = 4;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [3:0] p1_hit, p2_hit;
  logic [7:0] sound, drop_cnt;
  logic       busy, q_full;

  always #5 clk = ~clk;

  sound_event_scheduler #(
    .TONE_CYCLES(TONE), .GAP_CYCLES(GAP), .QDEPTH(QD), .CNT_W(27)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .sound(sound), .busy(busy), .q_full(q_full), .drop_cnt(drop_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit mchk = 1'b0;
  logic [7:0] s_sound, s_drop;
  logic       s_busy, s_full;

  // Reference model: a queue of pending codes plus the cycle at which the
  // scheduler is next idle; an issue happens the cycle after an idle,
  // non-empty cycle.
  logic [7:0] mq[$];
  logic [7:0] m_new[$];
  int  t_cyc = 0;
  int  idle_from = 0;
  bit  m_issue = 1'b0;
  bit  m_go, m_r1, m_r2;
  int  m_drop = 0;
  bit  m_rr = 1'b1;
  logic [3:0] m_prev1 = '0, m_prev2 = '0;

  function automatic logic [7:0] tone(input bit pl, input logic [3:0] n);
    for (int b = 3; b >= 0; b--)
      if (n[b]) return (pl ? 8'h10 : 8'h01) << b;
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_issue = 1'b0; idle_from = t_cyc + 1;
      m_drop = 0; m_rr = 1'b1; m_prev1 = '0; m_prev2 = '0;
    end else if (!enable) begin
      mq.delete();
      m_issue = 1'b0; idle_from = t_cyc + 1;
      m_prev1 = p1_hit; m_prev2 = p2_hit;
    end else begin
      m_go = !m_issue && (t_cyc >= idle_from) && (mq.size() != 0);
      if (m_issue) begin
        void'(mq.pop_front());
        idle_from = t_cyc + 1 + TONE + GAP;
      end
      m_r1 = (p1_hit != 0) && (m_prev1 == 0);
      m_r2 = (p2_hit != 0) && (m_prev2 == 0);
      m_new.delete();
      if (m_r1 && m_r2) begin
        if (m_rr) begin
          m_new.push_back(tone(0, p1_hit)); m_new.push_back(tone(1, p2_hit)); m_rr = 1'b0;
        end else begin
          m_new.push_back(tone(1, p2_hit)); m_new.push_back(tone(0, p1_hit)); m_rr = 1'b1;
        end
      end else if (m_r1) m_new.push_back(tone(0, p1_hit));
      else if (m_r2)     m_new.push_back(tone(1, p2_hit));
      foreach (m_new[k]) begin
        if (mq.size() < QD) mq.push_back(m_new[k]);
        else if (m_drop < 255) m_drop++;
      end
      m_prev1 = p1_hit; m_prev2 = p2_hit;
      m_issue = m_go;
    end
    t_cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs, sample outputs mid-cycle, check against the model.
  task automatic cyc(input logic r, input logic e, input logic [3:0] a, input logic [3:0] b);
    rst = r; enable = e; p1_hit = a; p2_hit = b;
    @(negedge clk);
    s_sound = sound; s_busy = busy; s_full = q_full; s_drop = drop_cnt;
    if (mchk) begin
      chk("model_sound", int'(s_sound), m_issue ? int'(mq[0]) : 0);
      chk("model_busy", int'(s_busy), int'(m_issue || t_cyc < idle_from || mq.size() != 0));
      chk("model_full", int'(s_full), int'(mq.size() == QD));
      chk("model_drop", int'(s_drop), m_drop);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] p1, p2;
    logic [7:0] sound;
    logic       busy, full;
    logic [7:0] drop;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [3:0] a, input logic [3:0] b,
                             input logic [7:0] s, input logic bz);
    vec_t x;
    x = '{rst: r, p1: a, p2: b, sound: s, busy: bz, full: 1'b0, drop: 8'h00};
    return x;
  endfunction

  typedef struct { int cyc; logic [7:0] code; } pulse_t;
  pulse_t got[$];
  pulse_t want[$];
  logic [3:0] a, b;

  initial begin
    rst = 1'b1; enable = 1'b1; p1_hit = '0; p2_hit = '0;
    @(posedge clk); #1;
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    mchk = 1'b1;

    // Single event, then a tie from reset followed by a second tie, then a held level.
    tbl.push_back(v(0, 4'b0010, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 1));
    tbl.push_back(v(0, 0, 0, 8'h02, 1));
    repeat (6) tbl.push_back(v(0, 0, 0, 8'h00, 1));
    repeat (2) tbl.push_back(v(0, 0, 0, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 4'b0001, 4'b1000, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 1));
    tbl.push_back(v(0, 0, 0, 8'h01, 1));
    repeat (7) tbl.push_back(v(0, 0, 0, 8'h00, 1));
    tbl.push_back(v(0, 0, 0, 8'h80, 1));
    repeat (6) tbl.push_back(v(0, 0, 0, 8'h00, 1));
    tbl.push_back(v(0, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 4'b0100, 4'b0010, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 1));
    tbl.push_back(v(0, 0, 0, 8'h20, 1));
    repeat (7) tbl.push_back(v(0, 0, 0, 8'h00, 1));
    tbl.push_back(v(0, 0, 0, 8'h04, 1));
    repeat (6) tbl.push_back(v(0, 0, 0, 8'h00, 1));
    tbl.push_back(v(0, 0, 0, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 4'b0111, 8'h00, 0));
    tbl.push_back(v(0, 0, 4'b0111, 8'h00, 1));
    tbl.push_back(v(0, 0, 4'b0111, 8'h40, 1));
    repeat (6) tbl.push_back(v(0, 0, 4'b0111, 8'h00, 1));
    tbl.push_back(v(0, 0, 4'b0111, 8'h00, 0));
    repeat (10) tbl.push_back(v(0, 0, 4'b0011, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 0));

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, 1, tbl[i].p1, tbl[i].p2);
      if (!tbl[i].rst) begin
        chk($sformatf("tbl%0d_sound", i), int'(s_sound), int'(tbl[i].sound));
        chk($sformatf("tbl%0d_busy", i), int'(s_busy), int'(tbl[i].busy));
        chk($sformatf("tbl%0d_full", i), int'(s_full), int'(tbl[i].full));
        chk($sformatf("tbl%0d_drop", i), int'(s_drop), int'(tbl[i].drop));
      end
    end

    // Overflow burst during a tone, then a push into a full FIFO on an issue
    // cycle. The issue at cycle 10 recycles a slot mid-burst, so only the
    // event at cycle 13 is dropped.
    cyc(1, 1, 0, 0);
    for (int c = 0; c < 58; c++) begin
      case (c)
        3: a = 4'b1000;  5: a = 4'b0100;  7: a = 4'b0010;  9: a = 4'b0001;
        11: a = 4'b1000; 13: a = 4'b0100; 18: a = 4'b0010;
        default: a = 4'b0000;
      endcase
      b = (c == 0) ? 4'b1000 : 4'b0000;
      cyc(0, 1, a, b);
      if (s_sound != 0) got.push_back('{c, s_sound});
      if (c == 9)  chk("ovf_full_before", int'(s_full), 0);
      if (c == 10) chk("ovf_full_after4", int'(s_full), 1);
      if (c == 14) chk("ovf_drop", int'(s_drop), 1);
      if (c == 18) chk("fullpop_full_issue", int'(s_full), 1);
      if (c == 19) chk("fullpop_full_after", int'(s_full), 1);
      if (c == 19) chk("fullpop_drop", int'(s_drop), 1);
      if (c == 57) chk("ovf_idle_busy", int'(s_busy), 0);
    end
    want = '{'{2, 8'h80}, '{10, 8'h08}, '{18, 8'h04}, '{26, 8'h02},
             '{34, 8'h01}, '{42, 8'h08}, '{50, 8'h02}};
    chk("ovf_pulse_count", got.size(), want.size());
    foreach (want[i]) if (i < got.size()) begin
      chk($sformatf("ovf_pulse%0d_cyc", i), got[i].cyc, want[i].cyc);
      chk($sformatf("ovf_pulse%0d_code", i), int'(got[i].code), int'(want[i].code));
    end

    // enable=0 abort mid-tone with three queued events; drop count survives,
    // the ignored request is not queued and a held input makes no new edge.
    cyc(0, 1, 4'b1000, 0);
    cyc(0, 1, 0, 4'b0001);
    cyc(0, 1, 4'b0100, 0);
    cyc(0, 1, 0, 4'b0010);
    cyc(0, 0, 4'b0010, 0);
    cyc(0, 1, 4'b0010, 0);
    chk("en_abort_sound", int'(s_sound), 0);
    chk("en_abort_busy", int'(s_busy), 0);
    chk("en_abort_full", int'(s_full), 0);
    chk("en_abort_drop_kept", int'(s_drop), 1);
    cyc(0, 1, 0, 0);
    chk("en_held_no_event", int'(s_busy), 0);
    cyc(0, 1, 4'b0001, 0);
    cyc(0, 1, 0, 0);
    chk("en_new_busy", int'(s_busy), 1);
    cyc(0, 1, 0, 0);
    chk("en_new_sound", int'(s_sound), 8'h01);
    repeat (8) cyc(0, 1, 0, 0);

    // Reset abort mid-tone with three queued events.
    cyc(0, 1, 4'b1000, 0);
    cyc(0, 1, 0, 4'b0001);
    cyc(0, 1, 4'b0100, 0);
    cyc(0, 1, 0, 4'b0010);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 4'b0001, 0);
    chk("rst_abort_sound", int'(s_sound), 0);
    chk("rst_abort_busy", int'(s_busy), 0);
    chk("rst_abort_drop", int'(s_drop), 0);
    cyc(0, 1, 0, 0);
    chk("rst_new_pending", int'(s_sound), 0);
    cyc(0, 1, 0, 0);
    chk("rst_new_sound", int'(s_sound), 8'h01);
    repeat (8) cyc(0, 1, 0, 0);

    // Random traffic with occasional disable and reset.
    for (int c = 0; c < 3000; c++) begin
      a = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) != 0), a, b);
    end

    // Saturation: heavy tied traffic drives the drop counter to its ceiling.
    cyc(1, 1, 0, 0);
    for (int c = 0; c < 600; c++) begin
      a = (c % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      b = (c % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cyc(0, 1, a, b);
    end
    chk("drop_saturate", int'(s_drop), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
